life_key_ctrl: RTL and testbench

- Consumer end of the debounced key-event interface: takes the 3-bit key code bus produced by the touch/key front end and turns it into Game-of-Life board actions.
- Actions: cursor movement with wrap-around, cell-flip requests and next-generation requests.
- Requests go to the board/engine over req/ack handshakes.
- Also generates a blinking cursor-visible flag for the display path.

---
 rtl/life_key_ctrl_pkg.sv | 37 +++
 rtl/life_key_ctrl_if.sv | 33 +++
 rtl/life_wrap_cnt.sv | 28 ++
 rtl/life_key_ctrl.sv | 151 +++++++++++++++
 tb/tb_life_key_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_key_ctrl_pkg.sv
// Shared definitions for the Game-of-Life key controller and the key front end.
// Holds the 3-bit key codes, the controller FSM encoding and small decode helpers.
// Ports: none (package).
package life_key_ctrl_pkg;

   // Key code bus type, shared with the debounced key front end
   typedef logic [2:0] key_code_t;

   localparam key_code_t KEY_IDLE  = 3'd0;
   localparam key_code_t KEY_UP    = 3'd1;
   localparam key_code_t KEY_DOWN  = 3'd2;
   localparam key_code_t KEY_LEFT  = 3'd3;
   localparam key_code_t KEY_RIGHT = 3'd4;
   localparam key_code_t KEY_FLIP  = 3'd5;
   localparam key_code_t KEY_NXT   = 3'd6;

   // Width of the cursor blink counter
   localparam int BLINK_W = 24;

   // Controller FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FLIP_WAIT = 2'd1,
      ST_GEN_WAIT  = 2'd2
   } ctrl_state_e;

   // Codes that produce events; IDLE and the unused code 7 do not
   function automatic logic is_event_code(input key_code_t k);
      return (k != KEY_IDLE) && (k != 3'd7);
   endfunction

   // Codes that move the cursor
   function automatic logic is_move_code(input key_code_t k);
      return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
   endfunction

endpackage

// File: rtl/life_key_ctrl_if.sv
// Bundle between the key controller, the key front end and the board engine.
// master: controller side (consumes keys/acks, drives cursor, requests, drop pulse).
// slave : environment side (drives keys and acks, observes everything else).
interface life_key_ctrl_if
   import life_key_ctrl_pkg::*;
#(
   parameter int XW = 4,
   parameter int YW = 4
);

   key_code_t      keys;        // debounced key code, IDLE between events
   logic [XW-1:0]  cur_x;       // cursor column
   logic [YW-1:0]  cur_y;       // cursor row
   logic           cursor_vis;  // blink phase for the cursor overlay
   logic           flip_req;    // invert cell at (flip_x, flip_y)
   logic [XW-1:0]  flip_x;      // stable while flip_req=1
   logic [YW-1:0]  flip_y;      // stable while flip_req=1
   logic           flip_ack;    // engine accepted the flip
   logic           gen_req;     // compute next generation
   logic           gen_ack;     // engine accepted/completed the generation
   logic           key_drop;    // 1-cycle pulse: event discarded while busy

   modport master (
      input  keys, flip_ack, gen_ack,
      output cur_x, cur_y, cursor_vis, flip_req, flip_x, flip_y, gen_req, key_drop
   );

   modport slave (
      output keys, flip_ack, gen_ack,
      input  cur_x, cur_y, cursor_vis, flip_req, flip_x, flip_y, gen_req, key_drop
   );

endinterface

// File: rtl/life_wrap_cnt.sv
// Up/down counter over 0..MAX with wrap-around in both directions.
// Latency: value updates on the edge after inc/dec; inc has priority over dec.
// Backpressure: none; ports clk_in, reset (async, active-high), inc, dec, val.
module life_wrap_cnt #(
   parameter int W   = 4,
   parameter int MAX = 15
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] val
);

   // Explicit compares so non-power-of-two ranges wrap correctly
   localparam logic [W-1:0] TOP = W'(MAX);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         val <= '0;
      end else if (inc) begin
         val <= (val == TOP) ? '0 : val + W'(1);
      end else if (dec) begin
         val <= (val == '0) ? TOP : val - W'(1);
      end
   end

endmodule

// File: rtl/life_key_ctrl.sv
// Turns debounced key events into cursor moves, cell-flip and next-generation requests.
// Latency: one cycle from the first non-idle key cycle to the registered outputs.
// Backpressure: while a flip/gen request awaits its ack, new events are dropped (key_drop).
//
// Ports: clk_in, reset (async, active-high), kif (life_key_ctrl_if.master):
//   keys in, flip_ack/gen_ack in, cur_x/cur_y/cursor_vis out,
//   flip_req/flip_x/flip_y out, gen_req out, key_drop out.
module life_key_ctrl
   import life_key_ctrl_pkg::*;
#(
   parameter int                   COLS      = 16,
   parameter int                   ROWS      = 16,
   parameter int                   XW        = $clog2(COLS),
   parameter int                   YW        = $clog2(ROWS),
   parameter logic [BLINK_W-1:0]   BLINK_DIV = 24'd6000000
) (
   input  logic                  clk_in,
   input  logic                  reset,
   life_key_ctrl_if.master       kif
);

   key_code_t           prev_keys;
   ctrl_state_e         state;
   logic [XW-1:0]       cur_x;
   logic [YW-1:0]       cur_y;
   logic [XW-1:0]       flip_x;
   logic [YW-1:0]       flip_y;
   logic                flip_req;
   logic                gen_req;
   logic                key_drop;
   logic                cursor_vis;
   logic [BLINK_W-1:0]  blink_cnt;

   logic key_ev;    // rising edge from IDLE to a valid code
   logic idle_ev;   // event that the controller will act on
   logic x_inc;
   logic x_dec;
   logic y_inc;
   logic y_dec;
   logic move_ev;

   // A held code only fires once because prev_keys is then non-idle;
   // switching directly between two codes never fires for the same reason.
   assign key_ev  = is_event_code(kif.keys) && (prev_keys == KEY_IDLE);
   assign idle_ev = key_ev && (state == ST_IDLE);
   assign x_inc   = idle_ev && (kif.keys == KEY_RIGHT);
   assign x_dec   = idle_ev && (kif.keys == KEY_LEFT);
   assign y_inc   = idle_ev && (kif.keys == KEY_DOWN);
   assign y_dec   = idle_ev && (kif.keys == KEY_UP);
   assign move_ev = idle_ev && is_move_code(kif.keys);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         prev_keys <= KEY_IDLE;
      end else begin
         prev_keys <= kif.keys;
      end
   end

   life_wrap_cnt #(.W(XW), .MAX(COLS - 1)) u_cnt_x (
      .clk_in (clk_in),
      .reset  (reset),
      .inc    (x_inc),
      .dec    (x_dec),
      .val    (cur_x)
   );

   life_wrap_cnt #(.W(YW), .MAX(ROWS - 1)) u_cnt_y (
      .clk_in (clk_in),
      .reset  (reset),
      .inc    (y_inc),
      .dec    (y_dec),
      .val    (cur_y)
   );

   // Request FSM. The req rises on the edge after the event, so an ack seen in
   // the event cycle is still in IDLE and ignored; only acks seen while waiting
   // (req already high) complete the handshake. An event arriving together with
   // the ack is still in a wait state and is therefore dropped.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         flip_req <= 1'b0;
         flip_x   <= '0;
         flip_y   <= '0;
         gen_req  <= 1'b0;
         key_drop <= 1'b0;
      end else begin
         key_drop <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_ev && (kif.keys == KEY_FLIP)) begin
                  flip_x   <= cur_x;
                  flip_y   <= cur_y;
                  flip_req <= 1'b1;
                  state    <= ST_FLIP_WAIT;
               end else if (key_ev && (kif.keys == KEY_NXT)) begin
                  gen_req  <= 1'b1;
                  state    <= ST_GEN_WAIT;
               end
            end
            ST_FLIP_WAIT: begin
               key_drop <= key_ev;
               if (kif.flip_ack) begin
                  flip_req <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            ST_GEN_WAIT: begin
               key_drop <= key_ev;
               if (kif.gen_ack) begin
                  gen_req <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               flip_req <= 1'b0;
               gen_req  <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Blink: a move restarts the phase with the cursor shown, so the user
   // always sees where the cursor landed.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         blink_cnt  <= '0;
         cursor_vis <= 1'b1;
      end else if (move_ev) begin
         blink_cnt  <= '0;
         cursor_vis <= 1'b1;
      end else if (blink_cnt == BLINK_DIV - BLINK_W'(1)) begin
         blink_cnt  <= '0;
         cursor_vis <= ~cursor_vis;
      end else begin
         blink_cnt  <= blink_cnt + BLINK_W'(1);
      end
   end

   assign kif.cur_x      = cur_x;
   assign kif.cur_y      = cur_y;
   assign kif.cursor_vis = cursor_vis;
   assign kif.flip_req   = flip_req;
   assign kif.flip_x     = flip_x;
   assign kif.flip_y     = flip_y;
   assign kif.gen_req    = gen_req;
   assign kif.key_drop   = key_drop;

endmodule

// File: tb/tb_life_key_ctrl.sv
// Bench for life_key_ctrl: a 16x16 and a 5x5 instance share one stimulus stream.
// Directed steps followed by random key/ack traffic, checked every cycle
// against a cycle-level behavioural model of the board controller.
module tb_life_key_ctrl;
   import life_key_ctrl_pkg::*;

   localparam int NB = 2;   // board 0: 16x16 div 7, board 1: 5x5 div 4

   logic      clk_in = 1'b0;
   logic      rst;
   key_code_t keys;
   logic      flip_ack;
   logic      gen_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   life_key_ctrl_if #(.XW(4), .YW(4)) if16 ();
   life_key_ctrl_if #(.XW(3), .YW(3)) if5 ();

   assign if16.keys     = keys;
   assign if16.flip_ack = flip_ack;
   assign if16.gen_ack  = gen_ack;
   assign if5.keys      = keys;
   assign if5.flip_ack  = flip_ack;
   assign if5.gen_ack   = gen_ack;

   life_key_ctrl #(.COLS(16), .ROWS(16), .BLINK_DIV(24'd7)) dut16 (
      .clk_in (clk_in),
      .reset  (rst),
      .kif    (if16)
   );

   life_key_ctrl #(.COLS(5), .ROWS(5), .BLINK_DIV(24'd4)) dut5 (
      .clk_in (clk_in),
      .reset  (rst),
      .kif    (if5)
   );

   // ---------------- behavioural model ----------------
   function automatic int dim(input int b);
      return (b == 0) ? 16 : 5;
   endfunction

   function automatic int bdiv(input int b);
      return (b == 0) ? 7 : 4;
   endfunction

   int        mx[NB], my[NB], mfx[NB], mfy[NB], mage[NB];
   bit        mfr[NB], mgr[NB], mdrop[NB];
   key_code_t mprev;
   bit        m_evt, m_moved;
   int        drops[NB];

   // Board is "busy" exactly while one of its requests is outstanding;
   // cursor visibility follows the number of cycles since the last move/reset.
   always @(posedge clk_in or posedge rst) begin
      if (rst) begin
         mprev = KEY_IDLE;
         for (int b = 0; b < NB; b++) begin
            mx[b] = 0; my[b] = 0; mfx[b] = 0; mfy[b] = 0; mage[b] = 0;
            mfr[b] = 0; mgr[b] = 0; mdrop[b] = 0;
         end
      end else begin
         m_evt = (keys >= 3'd1) && (keys <= 3'd6) && (mprev == KEY_IDLE);
         for (int b = 0; b < NB; b++) begin
            m_moved  = 0;
            mdrop[b] = 0;
            if (mfr[b] || mgr[b]) begin
               mdrop[b] = m_evt;
               if (mfr[b] && flip_ack) mfr[b] = 0;
               if (mgr[b] && gen_ack)  mgr[b] = 0;
            end else if (m_evt) begin
               case (keys)
                  KEY_UP:    begin my[b] = (my[b] + dim(b) - 1) % dim(b); m_moved = 1; end
                  KEY_DOWN:  begin my[b] = (my[b] + 1) % dim(b);          m_moved = 1; end
                  KEY_LEFT:  begin mx[b] = (mx[b] + dim(b) - 1) % dim(b); m_moved = 1; end
                  KEY_RIGHT: begin mx[b] = (mx[b] + 1) % dim(b);          m_moved = 1; end
                  KEY_FLIP:  begin mfx[b] = mx[b]; mfy[b] = my[b]; mfr[b] = 1; end
                  KEY_NXT:   mgr[b] = 1;
                  default:   ;
               endcase
            end
            mage[b] = m_moved ? 0 : mage[b] + 1;
         end
         mprev = keys;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("x16",    32'(if16.cur_x),      32'(mx[0]));
      chk("y16",    32'(if16.cur_y),      32'(my[0]));
      chk("vis16",  32'(if16.cursor_vis), 32'(((mage[0] / bdiv(0)) % 2) == 0));
      chk("freq16", 32'(if16.flip_req),   32'(mfr[0]));
      chk("fx16",   32'(if16.flip_x),     32'(mfx[0]));
      chk("fy16",   32'(if16.flip_y),     32'(mfy[0]));
      chk("greq16", 32'(if16.gen_req),    32'(mgr[0]));
      chk("drop16", 32'(if16.key_drop),   32'(mdrop[0]));
      chk("x5",     32'(if5.cur_x),       32'(mx[1]));
      chk("y5",     32'(if5.cur_y),       32'(my[1]));
      chk("vis5",   32'(if5.cursor_vis),  32'(((mage[1] / bdiv(1)) % 2) == 0));
      chk("freq5",  32'(if5.flip_req),    32'(mfr[1]));
      chk("fx5",    32'(if5.flip_x),      32'(mfx[1]));
      chk("fy5",    32'(if5.flip_y),      32'(mfy[1]));
      chk("greq5",  32'(if5.gen_req),     32'(mgr[1]));
      chk("drop5",  32'(if5.key_drop),    32'(mdrop[1]));
      if (if16.key_drop === 1'b1) drops[0]++;
      if (if5.key_drop === 1'b1)  drops[1]++;
   endtask

   // Advance n cycles; outputs sampled on the falling edge, inputs change there too
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         @(negedge clk_in);
         compare_all();
      end
   endtask

   task automatic press(input key_code_t code, input int hold);
      keys = code;
      tick(hold);
      keys = KEY_IDLE;
      tick(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int exp_y[5] = '{1, 2, 3, 4, 0};
      int n;
      logic v0;

      rst = 1'b1; keys = KEY_IDLE; flip_ack = 1'b0; gen_ack = 1'b0;
      tick(2);
      chk("rst_x16",   32'(if16.cur_x), 0);
      chk("rst_y5",    32'(if5.cur_y), 0);
      chk("rst_vis5",  32'(if5.cursor_vis), 1);
      chk("rst_freq5", 32'(if5.flip_req), 0);
      chk("rst_greq5", 32'(if5.gen_req), 0);
      chk("rst_drop5", 32'(if5.key_drop), 0);
      rst = 1'b0;
      tick(1);

      // Held LEFT yields exactly one event
      drops[0] = 0; drops[1] = 0;
      keys = KEY_LEFT;
      tick(2000);
      keys = KEY_IDLE;
      tick(2);
      chk("hold_left_x16", 32'(if16.cur_x), 15);
      chk("hold_left_y16", 32'(if16.cur_y), 0);
      chk("hold_left_x5",  32'(if5.cur_x), 4);
      chk("hold_left_nodrop", 32'(drops[0] + drops[1]), 0);

      // Non-power-of-two wrap on the 5x5 board
      for (int i = 0; i < 5; i++) begin
         press(KEY_DOWN, 3);
         chk("down_wrap_y5", 32'(if5.cur_y), 32'(exp_y[i]));
      end
      press(KEY_UP, 2);
      chk("up_wrap_y5", 32'(if5.cur_y), 4);
      chk("up_y16",     32'(if16.cur_y), 4);

      // Flip handshake with a dropped move while waiting
      do_reset();
      press(KEY_RIGHT, 2); press(KEY_RIGHT, 2); press(KEY_RIGHT, 2);
      press(KEY_DOWN, 2);  press(KEY_DOWN, 2);
      chk("pos_x5", 32'(if5.cur_x), 3);
      chk("pos_y5", 32'(if5.cur_y), 2);
      press(KEY_FLIP, 3);
      tick(50);
      chk("flip_req5",  32'(if5.flip_req), 1);
      chk("flip_x5",    32'(if5.flip_x), 3);
      chk("flip_y5",    32'(if5.flip_y), 2);
      chk("flip_req16", 32'(if16.flip_req), 1);
      keys = KEY_RIGHT;
      tick(1);
      chk("busy_drop_pulse", 32'(if5.key_drop), 1);
      keys = KEY_IDLE;
      tick(1);
      chk("busy_drop_end", 32'(if5.key_drop), 0);
      chk("busy_x5_held",  32'(if5.cur_x), 3);
      tick(2);
      flip_ack = 1'b1;
      tick(1);
      flip_ack = 1'b0;
      chk("flip_ack_drop_req", 32'(if5.flip_req), 0);
      tick(1);
      press(KEY_RIGHT, 2);
      chk("idle_after_flip_x5", 32'(if5.cur_x), 4);

      // gen_ack coinciding with a new event
      press(KEY_NXT, 2);
      chk("gen_req5", 32'(if5.gen_req), 1);
      keys = KEY_UP; gen_ack = 1'b1;
      tick(1);
      gen_ack = 1'b0;
      chk("gen_ack_req5", 32'(if5.gen_req), 0);
      chk("gen_ack_drop5", 32'(if5.key_drop), 1);
      keys = KEY_IDLE;
      tick(2);
      chk("gen_ack_y5", 32'(if5.cur_y), 2);

      // Direct code change without IDLE, and ignored code 7
      keys = KEY_UP;   tick(3);
      keys = KEY_LEFT; tick(3);
      keys = KEY_IDLE; tick(2);
      chk("nochain_y5", 32'(if5.cur_y), 1);
      chk("nochain_x5", 32'(if5.cur_x), 4);
      n = drops[1];
      press(3'd7, 3);
      chk("code7_x5", 32'(if5.cur_x), 4);
      chk("code7_y5", 32'(if5.cur_y), 1);
      chk("code7_nodrop", 32'(drops[1]), 32'(n));

      // Blink period and restart on move (5x5 board, divider 4)
      v0 = if5.cursor_vis; n = 0;
      while (if5.cursor_vis === v0 && n < 20) begin tick(1); n++; end
      chk("blink_edge_found", 32'(n < 20), 1);
      v0 = if5.cursor_vis; n = 0;
      while (if5.cursor_vis === v0 && n < 20) begin tick(1); n++; end
      chk("blink_period", 32'(n), 4);
      tick(2);
      keys = KEY_RIGHT;
      tick(1);
      keys = KEY_IDLE;
      chk("blink_move_vis", 32'(if5.cursor_vis), 1);
      tick(2);
      chk("blink_restart_e2", 32'(if5.cursor_vis), 1);
      tick(1);
      chk("blink_restart_e3", 32'(if5.cursor_vis), 1);
      tick(1);
      chk("blink_restart_e4", 32'(if5.cursor_vis), 0);

      // Asynchronous reset while a flip is pending
      press(KEY_FLIP, 2);
      chk("pre_rst_freq5", 32'(if5.flip_req), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_freq5", 32'(if5.flip_req), 0);
      chk("async_rst_freq16", 32'(if16.flip_req), 0);
      chk("async_rst_x16", 32'(if16.cur_x), 0);
      chk("async_rst_y5", 32'(if5.cur_y), 0);
      tick(2);
      rst = 1'b0;
      tick(1);

      // Random key and ack traffic
      for (int i = 0; i < 300; i++) begin
         int hold;
         keys = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 4);
         for (int c = 0; c < hold; c++) begin
            flip_ack = ($urandom_range(0, 3) == 0);
            gen_ack  = ($urandom_range(0, 3) == 0);
            tick(1);
         end
         if ($urandom_range(0, 2) != 0) begin
            keys = KEY_IDLE;
            tick($urandom_range(1, 3));
         end
      end
      keys = KEY_IDLE; flip_ack = 1'b0; gen_ack = 1'b0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
